mem_write_checker: RTL and testbench
====================================

MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the dataadr width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the writedata width.
REQ-003 SHALL have parameter NUM_CHECKS, default 4, meaning expected-write table depth (>=1).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 600, meaning RUN cycles allowed before timeout (>=1).
REQ-005 SHALL have parameter IGNORE_BASE, default 80, meaning tolerated scratch-address base.
REQ-006 SHALL have parameter IGNORE_MASK, default all ones, meaning address bits compared against IGNORE_BASE.
REQ-007 SHALL have port clk, input, 1 bit; the single clock, all state on rising edge.
REQ-008 SHALL have port reset, input, 1 bit; asynchronous, active-low reset.
REQ-009 SHALL have port start, input, 1 bit; begins a check run.
REQ-010 SHALL have ports memwrite (input, 1 bit), dataadr (input, ADDR_W bits) and writedata (input, DATA_W bits); the observed bus.
REQ-011 SHALL have ports cfg_we (input, 1 bit), cfg_idx (input, clog2(NUM_CHECKS), min 1, bits), cfg_addr (input, ADDR_W bits) and cfg_data (input, DATA_W bits); the table write port.
REQ-012 SHALL have ports busy, done, pass and fail, each output, 1 bit; run status.
REQ-013 SHALL have port fail_code, output, 2 bits: 0 none, 1 bad address, 2 bad data, 3 timeout.
REQ-014 SHALL have ports fail_addr (output, ADDR_W bits) and fail_data (output, DATA_W bits); the write that caused failure.
REQ-015 SHALL have port match_count, output, clog2(NUM_CHECKS+1) bits; expected writes matched so far.

Function
REQ-016 SHALL implement states IDLE, RUN, PASS and FAIL; busy=RUN, done=PASS|FAIL, pass=PASS, fail=FAIL.
REQ-017 SHALL write table entry cfg_idx with {cfg_addr, cfg_data} on a rising edge with cfg_we=1, only when not in RUN; cfg_we in RUN is ignored; cfg_idx>=NUM_CHECKS is ignored.
REQ-018 SHALL, on start=1 in IDLE, PASS or FAIL, enter RUN next cycle and clear match_count, cycle counter, fail_code, fail_addr and fail_data; start in RUN is ignored.
REQ-019 SHALL, in RUN, sample memwrite/dataadr/writedata on each rising edge and compare against entry[match_count] (the in-order expected write).
REQ-020 SHALL, when memwrite=1 and dataadr==expected address and writedata==expected data, increment match_count; if the new count equals NUM_CHECKS, go to PASS.
REQ-021 SHALL, when memwrite=1 and dataadr==expected address but writedata differs, go to FAIL with fail_code=2 and capture dataadr/writedata.
REQ-022 SHALL, when memwrite=1 with address not expected and (dataadr & IGNORE_MASK)==(IGNORE_BASE & IGNORE_MASK), ignore the write; expected-address comparison takes priority over the ignore window.
REQ-023 SHALL, on any other memwrite=1 in RUN, go to FAIL with fail_code=1 and capture dataadr/writedata.
REQ-024 SHALL count RUN cycles; when the count reaches TIMEOUT_CYCLES-1 without a transition to PASS or FAIL on that edge, go to FAIL with fail_code=3, fail_addr/fail_data=0.
REQ-025 SHALL give a same-edge final match priority over timeout (PASS wins).
REQ-026 SHALL ignore bus activity in IDLE, PASS and FAIL; status holds until start or reset.
REQ-027 SHALL have single-cycle latency: status reflects the triggering write on the following edge.

Reset
REQ-028 SHALL, while reset=0, asynchronously force IDLE, busy=done=pass=fail=0, fail_code=0, fail_addr=0, fail_data=0, match_count=0, cycle counter=0 and every table entry=0.
REQ-029 SHALL abort a run when reset is asserted mid-RUN, returning to IDLE and requiring new table load and start after release.

Verification
REQ-030 SHALL pass this scenario: NUM_CHECKS=1, entry0={84,7}, start, writes (80,3),(80,5),(84,7) -> pass=1, match_count=1, fail=0.
REQ-031 SHALL pass this scenario: entry0={84,7}, start, write (88,7) -> fail=1, fail_code=1, fail_addr=88, fail_data=7.
REQ-032 SHALL pass this scenario: entry0={84,7}, start, write (84,6) -> fail_code=2, fail_addr=84, fail_data=6.
REQ-033 SHALL pass this scenario: TIMEOUT_CYCLES=10, start, no writes -> fail_code=3 exactly 10 edges after entering RUN; with (84,7) on edge 10 -> pass=1 instead.
REQ-034 SHALL pass this scenario: NUM_CHECKS=4, entries {84,7},{88,1},{92,2},{96,3}, writes in order with (80,x) interleaved -> pass, match_count=4; out-of-order (88,1) first -> fail_code=1.
REQ-035 SHALL pass this scenario: reset=0 mid-RUN after 2 matches -> immediate IDLE, all outputs 0, table cleared; cfg_we during RUN leaves the table unchanged.

Source files
------------

// File: rtl/mem_write_checker.sv
// Bus-write checker: watches memwrite/dataadr/writedata during a run and
// matches it in order against a small table of expected writes. Writes to a
// scratch window are tolerated, and a run that goes on too long times out.
module mem_write_checker #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned NUM_CHECKS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 600,
  parameter logic [ADDR_W-1:0] IGNORE_BASE = ADDR_W'(80),
  parameter logic [ADDR_W-1:0] IGNORE_MASK = '1,
  localparam int unsigned IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int unsigned MC_W  = $clog2(NUM_CHECKS + 1),
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        fail_code,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [MC_W-1:0]   match_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_ADDR    = 2'd1;
  localparam logic [1:0] CODE_DATA    = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT = 2'd3;

  state_t             state;
  logic [CNT_W-1:0]   cycle_cnt;
  logic [ADDR_W-1:0]  tbl_addr [NUM_CHECKS];
  logic [DATA_W-1:0]  tbl_data [NUM_CHECKS];

  logic [ADDR_W-1:0]  exp_addr;
  logic [DATA_W-1:0]  exp_data;
  logic               addr_hit;
  logic               good_hit;
  logic               bad_data;
  logic               stray;
  logic               last_match;
  logic               timed_out;

  // Select the next expected write and classify the current bus cycle.
  always_comb begin
    exp_addr = '0;
    exp_data = '0;
    for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
      if (match_count == MC_W'(i)) begin
        exp_addr = tbl_addr[i];
        exp_data = tbl_data[i];
      end
    end
    addr_hit   = memwrite && (dataadr == exp_addr);
    good_hit   = addr_hit && (writedata == exp_data);
    bad_data   = addr_hit && (writedata != exp_data);
    // Expected-address match is checked first, so an expected write that
    // happens to fall inside the scratch window is still honoured.
    stray      = memwrite && !addr_hit &&
                 ((dataadr & IGNORE_MASK) != (IGNORE_BASE & IGNORE_MASK));
    last_match = good_hit && (match_count == MC_W'(NUM_CHECKS - 1));
    timed_out  = (cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // Expected-write table; writable only outside a run, out-of-range index dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
        tbl_addr[i] <= '0;
        tbl_data[i] <= '0;
      end
    end else if (cfg_we && (state != S_RUN)) begin
      for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
        if (cfg_idx == IDX_W'(i)) begin
          tbl_addr[i] <= cfg_addr;
          tbl_data[i] <= cfg_data;
        end
      end
    end
  end

  // Run control: start, in-order matching, failure capture and timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cycle_cnt   <= '0;
      match_count <= '0;
      fail_code   <= CODE_NONE;
      fail_addr   <= '0;
      fail_data   <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (good_hit) begin
            match_count <= match_count + MC_W'(1);
          end
          // Final match beats a same-edge timeout; capture faults before timeout.
          if (last_match) begin
            state <= S_PASS;
          end else if (bad_data) begin
            state     <= S_FAIL;
            fail_code <= CODE_DATA;
            fail_addr <= dataadr;
            fail_data <= writedata;
          end else if (stray) begin
            state     <= S_FAIL;
            fail_code <= CODE_ADDR;
            fail_addr <= dataadr;
            fail_data <= writedata;
          end else if (timed_out) begin
            state     <= S_FAIL;
            fail_code <= CODE_TIMEOUT;
            fail_addr <= '0;
            fail_data <= '0;
          end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end
        default: begin
          if (start) begin
            state       <= S_RUN;
            cycle_cnt   <= '0;
            match_count <= '0;
            fail_code   <= CODE_NONE;
            fail_addr   <= '0;
            fail_data   <= '0;
          end
        end
      endcase
    end
  end

  // Status flags decoded straight from the state register.
  always_comb begin
    busy = (state == S_RUN);
    pass = (state == S_PASS);
    fail = (state == S_FAIL);
    done = pass || fail;
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: directed scenarios plus a randomized phase,
// checked against a queue-based reference model. Two instances: a (4 entries,
// 40-cycle timeout) and b (1 entry, 10-cycle timeout).
module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic        memwrite;
  logic [31:0] dataadr, writedata;
  logic        cfg_we_a, cfg_we_b;
  logic [1:0]  cfg_idx_a;
  logic [0:0]  cfg_idx_b;
  logic [31:0] cfg_addr, cfg_data;

  logic        busy_a, done_a, pass_a, fail_a;
  logic [1:0]  fail_code_a;
  logic [31:0] fail_addr_a, fail_data_a;
  logic [2:0]  mc_a;
  logic        busy_b, done_b, pass_b, fail_b;
  logic [1:0]  fail_code_b;
  logic [31:0] fail_addr_b, fail_data_b;
  logic [0:0]  mc_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_write_checker #(.NUM_CHECKS(4), .TIMEOUT_CYCLES(40)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .cfg_we(cfg_we_a),
    .cfg_idx(cfg_idx_a), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail(fail_a),
    .fail_code(fail_code_a), .fail_addr(fail_addr_a), .fail_data(fail_data_a),
    .match_count(mc_a)
  );

  mem_write_checker #(.NUM_CHECKS(1), .TIMEOUT_CYCLES(10)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .cfg_we(cfg_we_b),
    .cfg_idx(cfg_idx_b), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail(fail_b),
    .fail_code(fail_code_b), .fail_addr(fail_addr_b), .fail_data(fail_data_b),
    .match_count(mc_b)
  );

  // ---------------- reference model ----------------
  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;

  function automatic int nchk(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int tmo(input int k);
    return (k == 0) ? 40 : 10;
  endfunction

  wr_t         tbl   [2][4];
  wr_t         pend  [2][$];   // writes still owed in the current run
  int          m_st  [2];      // 0 idle, 1 run, 2 pass, 3 fail
  int          m_mc  [2];
  int          m_edges [2];    // edges seen since entering run
  int          m_code [2];
  logic [31:0] m_fa  [2];
  logic [31:0] m_fd  [2];

  always @(posedge clk or negedge reset) begin
    bit we, go, was_run;
    int idx;
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_st[k] = 0; m_mc[k] = 0; m_edges[k] = 0; m_code[k] = 0;
        m_fa[k] = '0; m_fd[k] = '0;
        pend[k].delete();
        for (int i = 0; i < 4; i++) tbl[k][i] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        we  = (k == 0) ? cfg_we_a : cfg_we_b;
        go  = (k == 0) ? start_a : start_b;
        idx = (k == 0) ? int'(cfg_idx_a) : int'(cfg_idx_b);
        was_run = (m_st[k] == 1);
        if (!was_run && we && idx < nchk(k)) tbl[k][idx] = {cfg_addr, cfg_data};
        if (was_run) begin
          m_edges[k]++;
          if (memwrite) begin
            if (dataadr == pend[k][0].a) begin
              if (writedata == pend[k][0].d) begin
                void'(pend[k].pop_front());
                m_mc[k]++;
                if (pend[k].size() == 0) m_st[k] = 2;
              end else begin
                m_st[k] = 3; m_code[k] = 2; m_fa[k] = dataadr; m_fd[k] = writedata;
              end
            end else if (dataadr != 32'd80) begin
              m_st[k] = 3; m_code[k] = 1; m_fa[k] = dataadr; m_fd[k] = writedata;
            end
          end
          if (m_st[k] == 1 && m_edges[k] == tmo(k)) begin
            m_st[k] = 3; m_code[k] = 3; m_fa[k] = '0; m_fd[k] = '0;
          end
        end else if (go) begin
          m_st[k] = 1; m_mc[k] = 0; m_edges[k] = 0; m_code[k] = 0;
          m_fa[k] = '0; m_fd[k] = '0;
          pend[k].delete();
          for (int i = 0; i < nchk(k); i++) pend[k].push_back(tbl[k][i]);
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("a_busy", busy_a, m_st[0] == 1);
    chk("a_done", done_a, m_st[0] >= 2);
    chk("a_pass", pass_a, m_st[0] == 2);
    chk("a_fail", fail_a, m_st[0] == 3);
    chk("a_code", fail_code_a, m_code[0]);
    chk("a_faddr", fail_addr_a, m_fa[0]);
    chk("a_fdata", fail_data_a, m_fd[0]);
    chk("a_mc", mc_a, m_mc[0]);
    chk("b_busy", busy_b, m_st[1] == 1);
    chk("b_done", done_b, m_st[1] >= 2);
    chk("b_pass", pass_b, m_st[1] == 2);
    chk("b_fail", fail_b, m_st[1] == 3);
    chk("b_code", fail_code_b, m_code[1]);
    chk("b_faddr", fail_addr_b, m_fa[1]);
    chk("b_fdata", fail_data_b, m_fd[1]);
    chk("b_mc", mc_b, m_mc[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d);
    memwrite = w; dataadr = a; writedata = d;
  endtask

  task automatic load_a(input int idx, input logic [31:0] a, input logic [31:0] d);
    cfg_we_a = 1'b1; cfg_idx_a = 2'(idx); cfg_addr = a; cfg_data = d;
    tick();
    cfg_we_a = 1'b0;
  endtask

  task automatic go_a();
    start_a = 1'b1; tick(); start_a = 1'b0;
  endtask

  task automatic go_b();
    start_b = 1'b1; tick(); start_b = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr(input int sel);
    case (sel)
      0: return 32'd80;
      1: return 32'd84;
      2: return 32'd88;
      default: return 32'd92;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; start_a = 0; start_b = 0; cfg_we_a = 0; cfg_we_b = 0;
    cfg_idx_a = '0; cfg_idx_b = '0; cfg_addr = '0; cfg_data = '0;
    bus(0, '0, '0);
    tick(); tick();
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_code", fail_code_a, 0);
    chk("rst_mc", mc_a, 0);
    reset = 1'b1;
    tick();

    // one-entry pass with scratch writes in between
    cfg_we_b = 1; cfg_idx_b = 1'b0; cfg_addr = 32'd84; cfg_data = 32'd7;
    tick(); cfg_we_b = 0;
    go_b();
    chk("s30_busy", busy_b, 1);
    bus(1, 80, 3); tick();
    bus(1, 80, 5); tick();
    bus(1, 84, 7); tick();
    bus(0, 0, 0);
    chk("s30_pass", pass_b, 1);
    chk("s30_mc", mc_b, 1);
    chk("s30_fail", fail_b, 0);

    // timeout exactly 10 edges into the run
    go_b();
    repeat (9) tick();
    chk("s33_notyet", fail_b, 0);
    tick();
    chk("s33_fail", fail_b, 1);
    chk("s33_code", fail_code_b, 3);
    chk("s33_faddr", fail_addr_b, 0);
    // final match on the timeout edge wins
    go_b();
    repeat (9) tick();
    bus(1, 84, 7); tick(); bus(0, 0, 0);
    chk("s33_pass", pass_b, 1);
    chk("s33_nofail", fail_b, 0);

    // bad address
    load_a(0, 84, 7);
    go_a();
    bus(1, 88, 7); tick(); bus(0, 0, 0);
    chk("s31_fail", fail_a, 1);
    chk("s31_code", fail_code_a, 1);
    chk("s31_faddr", fail_addr_a, 88);
    chk("s31_fdata", fail_data_a, 7);

    // bad data
    go_a();
    chk("s32_cleared", fail_code_a, 0);
    bus(1, 84, 6); tick(); bus(0, 0, 0);
    chk("s32_code", fail_code_a, 2);
    chk("s32_faddr", fail_addr_a, 84);
    chk("s32_fdata", fail_data_a, 6);

    // four in-order writes with scratch traffic interleaved
    load_a(1, 88, 1); load_a(2, 92, 2); load_a(3, 96, 3);
    go_a();
    bus(1, 84, 7); tick();
    bus(1, 80, 5); tick();
    bus(1, 88, 1); tick();
    bus(1, 80, 9); tick();
    bus(1, 92, 2); tick();
    bus(1, 96, 3); tick();
    bus(0, 0, 0);
    chk("s34_pass", pass_a, 1);
    chk("s34_mc", mc_a, 4);
    go_a();
    bus(1, 88, 1); tick(); bus(0, 0, 0);
    chk("s34_ooo_code", fail_code_a, 1);
    chk("s34_ooo_mc", mc_a, 0);

    // table write during a run is ignored; reset mid-run clears everything
    go_a();
    bus(1, 84, 7); tick();
    bus(1, 88, 1); tick();
    bus(0, 0, 0);
    chk("s35_mc2", mc_a, 2);
    cfg_we_a = 1; cfg_idx_a = 2'd2; cfg_addr = 32'd92; cfg_data = 32'd99;
    tick(); cfg_we_a = 0;
    bus(1, 92, 2); tick(); bus(0, 0, 0);
    chk("s35_tbl_kept", mc_a, 3);
    reset = 1'b0;
    #1;
    compare_all();
    chk("s35_busy", busy_a, 0);
    chk("s35_done", done_a, 0);
    chk("s35_mc", mc_a, 0);
    reset = 1'b1;
    tick();
    go_a();
    bus(1, 0, 0); tick(); bus(0, 0, 0);
    chk("s35_cleared_mc", mc_a, 1);
    chk("s35_cleared_busy", busy_a, 1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      start_a   = ($urandom_range(0, 31) == 0);
      start_b   = ($urandom_range(0, 15) == 0);
      cfg_we_a  = ($urandom_range(0, 3) == 0);
      cfg_we_b  = ($urandom_range(0, 3) == 0);
      cfg_idx_a = 2'($urandom_range(0, 3));
      cfg_idx_b = 1'($urandom_range(0, 1));
      cfg_addr  = pick_addr($urandom_range(0, 2));
      cfg_data  = 32'($urandom_range(0, 1));
      bus($urandom_range(0, 5) == 0, pick_addr($urandom_range(0, 3)),
          32'($urandom_range(0, 1)));
      tick();
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        #1;
        compare_all();
        reset = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
